div_m_gen: RTL

Programmable integer divider that generates the `DIV_M` reference clock for the FMDLL post-divider stage.
- Divides `clk_ext` by a ratio N selected by the 2-bit code `M`.
- Produces a glitch-free divided output plus companion status: rising-edge tick, lock-valid flag, ratio-update pulse.
- Ratio changes take effect only on period boundaries, so the downstream `/2` and `/4` dividers never see a runt pulse.

---
 rtl/div_m_gen.sv | 74 +++++++
 1 files changed

// File: rtl/div_m_gen.sv
// div_m_gen: programmable /N clock divider (N=1..4) with tick, lock-valid and ratio-update status
module div_m_gen #(
    parameter int VALID_PERIODS = 2
) (
    input  logic       clk_ext,
    input  logic       rst,
    input  logic [1:0] M,
    output logic       DIV_M,
    output logic       div_tick,
    output logic       div_valid,
    output logic       m_upd,
    output logic [2:0] ratio
);
    localparam logic [2:0] PMAX = 3'(VALID_PERIODS + 1);

    logic [1:0] m_act;
    logic [1:0] cnt;
    logic [2:0] per_cnt;
    logic       wrap;
    logic       chg;
    logic [2:0] n_new;
    logic [2:0] per_inc;

    function automatic logic [2:0] n_of(input logic [1:0] c);
        return (c == 2'd0) ? 3'd4 : {1'b0, c};
    endfunction

    // high-phase length: ceil(N/2)
    function automatic logic [2:0] h_of(input logic [2:0] n);
        return (n + 3'd1) >> 1;
    endfunction

    // wrap detection, ratio adoption and saturating period count
    always_comb begin
        wrap    = ({1'b0, cnt} == ratio - 3'd1);
        chg     = wrap && (M != m_act);
        n_new   = chg ? n_of(M) : ratio;
        per_inc = (per_cnt == PMAX) ? PMAX : per_cnt + 3'd1;
    end

    // phase counter and flopped outputs; ratio changes only at period boundaries
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            m_act     <= M;
            ratio     <= n_of(M);
            cnt       <= 2'(n_of(M) - 3'd1);
            per_cnt   <= 3'd0;
            DIV_M     <= 1'b0;
            div_tick  <= 1'b0;
            div_valid <= 1'b0;
            m_upd     <= 1'b0;
        end else if (!wrap) begin
            cnt      <= cnt + 2'd1;
            DIV_M    <= ({1'b0, cnt} + 3'd1 < h_of(ratio));
            div_tick <= 1'b0;
            m_upd    <= 1'b0;
        end else begin
            cnt      <= 2'd0;
            DIV_M    <= (n_new != 3'd1);
            div_tick <= (n_new != 3'd1);
            if (chg) begin
                m_act     <= M;
                ratio     <= n_new;
                per_cnt   <= 3'd1;
                div_valid <= 1'b0;
                m_upd     <= 1'b1;
            end else begin
                per_cnt   <= per_inc;
                div_valid <= (per_inc == PMAX);
                m_upd     <= 1'b0;
            end
        end
    end
endmodule
